map_bankwin_irq: RTL and testbench
==================================

Name: map_bankwin_irq

Overview:
- Parametrised discrete-logic mapper for the NES cartridge core.
- Next generation of the single-register PRG-window mappers:
  - switchable 8 KB PRG window at $6000-$7FFF;
  - fixed last 32 KB of PRG at $8000-$FFFF;
  - CHR bank register and software mirroring control;
  - CPU-cycle IRQ counter.
- Provides save-state read/write of all internal registers.
- Sits between the core's CPU/PPU bus decode and the PRG/CHR memory address generators.

Parameters:
- PRG_BANK_W, 4: width of the PRG window bank register. PRG address width is PRG_BANK_W+13.
- CHR_BANK_W, 2: width of the CHR 8 KB bank register.
- IRQ_W, 15: width of the IRQ cycle counter.
- IRQ_PERIOD, 24576: counter terminal count. Must satisfy 2 <= IRQ_PERIOD <= 2^IRQ_W.
- MIR_RST, 1: reset value of mir_v (1 = vertical mirroring).

Ports:
- m2  in  1  CPU M2 clock. The single clock; all state updates on the falling edge.
- map_rst_n  in  1  Reset, synchronous, active-low, sampled on the m2 falling edge.
- cpu_addr  in  15  CPU A14..A0.
- cpu_dat  in  8  CPU write data.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_ce  in  1  Active-low; low means $8000-$FFFF.
- ss_act  in  1  Save-state engine active.
- ss_we  in  1  Save-state write strobe.
- ss_addr  in  8  Save-state register index.
- map_idx  in  8  Mapper number, returned at ss_addr 127.
- ss_rdat  out  8  Save-state readback, combinational.
- rom_ce  out  1  PRG ROM select: ($6000-$7FFF) or ($8000-$FFFF).
- prg_addr  out  PRG_BANK_W+13  PRG ROM address.
- chr_bank  out  CHR_BANK_W  CHR bank; chr_addr[CHR_BANK_W+12:13].
- mir_v  out  1  1 = vertical (ciram_a10 = ppu A10), 0 = horizontal (A11).
- irq  out  1  Active-high IRQ request to the core (core inverts for /IRQ).

Behaviour:
- Register writes apply on m2 fall when !cpu_ce & !cpu_rw & !ss_act. Decode by cpu_addr[14:12]:
  - 000 ($8000-$8FFF): prg_bank <= cpu_dat[PRG_BANK_W-1:0].
  - 001 ($9000-$9FFF): chr_bank <= cpu_dat[CHR_BANK_W-1:0].
  - 010 ($A000-$AFFF): mir_v <= cpu_dat[0]; irq_en <= cpu_dat[1].
    - If cpu_dat[1]==0: counter <= 0 and irq <= 0 in the same edge.
  - 011 ($B000-$BFFF): IRQ acknowledge; irq <= 0, counter untouched.
  - 1xx: ignored.
- PRG mapping (combinational):
  - cpu_ce=1 (below $8000): prg_addr = {prg_bank, cpu_addr[12:0]}.
  - cpu_ce=0: prg_addr = {all-ones upper bits, cpu_addr[14:13], cpu_addr[12:0]}, i.e. the last 32 KB.
  - If PRG_BANK_W < 2, the fixed region is truncated to the available address width.
- rom_ce = (cpu_addr[14:13]==2'b11 & cpu_ce) | !cpu_ce. Zero latency.
- IRQ counter:
  - While irq_en & !ss_act, increments by 1 every m2 fall.
  - On reaching IRQ_PERIOD-1, the next edge wraps it to 0 and sets irq <= 1.
  - irq stays high until ack, disable, or reset; it is not re-cleared by the wrap.
  - Simultaneous register write and counter event: the write's effect on counter/irq wins. Ack on the wrap edge leaves irq=0, counter=0.
  - Counter width arithmetic: unsigned IRQ_W bits; compare against IRQ_PERIOD-1 as an IRQ_W constant.
- Reset (map_rst_n=0 at m2 fall):
  - prg_bank=0, chr_bank=0, mir_v=MIR_RST, irq_en=0, counter=0, irq=0.
  - Overrides any concurrent CPU or save-state write.
  - Reset mid-count drops irq on that same edge.
- Save state (ss_act=1):
  - CPU writes are ignored and the counter is frozen.
  - ss_we writes indices 0..5 on m2 fall:
    - 0: prg_bank, LSB-aligned.
    - 1: chr_bank.
    - 2: {irq, irq_en, mir_v} in bits 2:0.
    - 3: counter[7:0].
    - 4: counter[IRQ_W-1:8].
    - 5: reserved; reads as 0.
  - ss_rdat returns the same fields zero-padded; index 127 = map_idx; all other indices = 8'hFF.
- Unused high bits of a written byte are discarded.

Decomposition:
- Shared package / defs include holds:
  - register-select constants (REG_PRG=3'd0, REG_CHR=3'd1, REG_CTL=3'd2, REG_ACK=3'd3);
  - save-state index constants (SS_PRG..SS_CNTH, SS_IDX=127);
  - control-bit positions.
- One sub-module: map_irq_cyc. Holds counter, irq_en, and irq, with ports for enable-write, ack, save-state load, and freeze. Parametrised by IRQ_W and IRQ_PERIOD.

Test Plan:
- Reset, then read $6000 and $8000 -> prg_addr = 0x00000 and 0x18000 (PRG_BANK_W=4); mir_v=1; irq=0.
- Write $8000=0x0B, then read $7123 -> prg_addr=0x17123. Then write $8FFF=0xF3 -> prg_bank=3. A write to $C000 leaves all registers unchanged.
- Write $A000=0x02, then count m2 falls:
  - irq rises exactly 24576 edges after the write edge.
  - counter=0 on that edge.
  - Write $B000 -> irq=0 and the counter keeps running. The next irq arrives 24576 edges later.
- Write $A000=0x02, wait 100 edges, then write $A000=0x01 -> counter=0, irq=0, mir_v=1. No irq within 30000 edges.
- ss_act=1:
  - ss write idx3=0xFE, idx4=0x5F, idx2=0x02; CPU write $8000=0x05 is ignored.
  - Release ss_act -> irq after 2 edges. ss_rdat at idx127 = map_idx; idx9 = 0xFF.
- Assert map_rst_n=0 on the same edge as a write to $8000=0x07 during an active count -> all registers reset, prg_bank=0, irq=0.

Source files
------------

// File: rtl/map_bankwin_irq_pkg.sv
// map_bankwin_irq_pkg: shared constants for the bank-window IRQ mapper.
//   - CPU register selects, decoded from cpu_addr[14:12]
//   - save-state register indices
//   - bit positions inside the control byte
package map_bankwin_irq_pkg;

    // CPU register selects; 3'b1xx is unmapped.
    localparam logic [2:0] REG_PRG = 3'd0;
    localparam logic [2:0] REG_CHR = 3'd1;
    localparam logic [2:0] REG_CTL = 3'd2;
    localparam logic [2:0] REG_ACK = 3'd3;

    // Save-state register indices.
    localparam logic [7:0] SS_PRG  = 8'd0;
    localparam logic [7:0] SS_CHR  = 8'd1;
    localparam logic [7:0] SS_CTL  = 8'd2;
    localparam logic [7:0] SS_CNTL = 8'd3;
    localparam logic [7:0] SS_CNTH = 8'd4;
    localparam logic [7:0] SS_RSVD = 8'd5;
    localparam logic [7:0] SS_IDX  = 8'd127;

    // Control byte layout.
    // CPU writes use CTL_MIR and CTL_IRQ_EN; save-state also carries CTL_IRQ.
    localparam int unsigned CTL_MIR    = 0;
    localparam int unsigned CTL_IRQ_EN = 1;
    localparam int unsigned CTL_IRQ    = 2;

endpackage

// File: rtl/map_bankwin_irq_if.sv
// map_bankwin_irq_if: CPU-side bus, save-state port and mapper outputs.
//   master: the core side. It drives the CPU bus and the save-state controls,
//           and receives the mapper outputs.
//   slave : the mapper side.
//   Signals:
//     cpu_addr  A14..A0
//     cpu_dat   write data; also the save-state write data
//     cpu_rw    1 = read
//     cpu_ce    active-low $8000-$FFFF
//     ss_*      save-state controls
//     map_idx   mapper number
//     ss_rdat   combinational readback
//     rom_ce, prg_addr, chr_bank, mir_v, irq
interface map_bankwin_irq_if #(
    parameter int unsigned PRG_BANK_W = 4,
    parameter int unsigned CHR_BANK_W = 2
);
    logic [14:0]            cpu_addr;
    logic [7:0]             cpu_dat;
    logic                   cpu_rw;
    logic                   cpu_ce;
    logic                   ss_act;
    logic                   ss_we;
    logic [7:0]             ss_addr;
    logic [7:0]             map_idx;
    logic [7:0]             ss_rdat;
    logic                   rom_ce;
    logic [PRG_BANK_W+12:0] prg_addr;
    logic [CHR_BANK_W-1:0]  chr_bank;
    logic                   mir_v;
    logic                   irq;

    modport master (
        output cpu_addr, cpu_dat, cpu_rw, cpu_ce, ss_act, ss_we, ss_addr, map_idx,
        input  ss_rdat, rom_ce, prg_addr, chr_bank, mir_v, irq
    );

    modport slave (
        input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, ss_act, ss_we, ss_addr, map_idx,
        output ss_rdat, rom_ce, prg_addr, chr_bank, mir_v, irq
    );
endinterface

// File: rtl/map_irq_cyc.sv
// map_irq_cyc: CPU-cycle IRQ counter. It holds the counter, irq_en and irq.
//   m2, map_rst_n  clock (falling edge) and synchronous active-low reset
//   freeze         holds the counter, used while save-state is active
//   en_we/en_wdat  control write; en_wdat=0 also clears the counter and irq
//   ack            clears irq; the counter is left alone
//   ss_*_we        save-state loads of the control bits, counter[7:0], counter[IRQ_W-1:8]
//   ss_wdat        save-state write byte
//   counter, irq_en, irq  state outputs
// IRQ_W must lie between 9 and 16 so that the save-state byte split holds.
module map_irq_cyc
    import map_bankwin_irq_pkg::*;
#(
    parameter int unsigned IRQ_W      = 15,
    parameter int unsigned IRQ_PERIOD = 24576
) (
    input  logic             m2,
    input  logic             map_rst_n,
    input  logic             freeze,
    input  logic             en_we,
    input  logic             en_wdat,
    input  logic             ack,
    input  logic             ss_ctl_we,
    input  logic             ss_lo_we,
    input  logic             ss_hi_we,
    input  logic [7:0]       ss_wdat,
    output logic [IRQ_W-1:0] counter,
    output logic             irq_en,
    output logic             irq
);
    localparam logic [IRQ_W-1:0] TERM = IRQ_W'(IRQ_PERIOD - 1);

    logic [IRQ_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             irq_q, irq_d;

    // The counter update is applied first. Writes that follow it override it.
    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        irq_d = irq_q;
        if (en_q && !freeze) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                irq_d = 1'b1;
            end else begin
                cnt_d = cnt_q + IRQ_W'(1);
            end
        end
        if (en_we) begin
            en_d = en_wdat;
            if (!en_wdat) begin
                cnt_d = '0;
                irq_d = 1'b0;
            end
        end
        if (ack) begin
            irq_d = 1'b0;
        end
        if (ss_ctl_we) begin
            en_d  = ss_wdat[CTL_IRQ_EN];
            irq_d = ss_wdat[CTL_IRQ];
        end
        if (ss_lo_we) begin
            cnt_d[7:0] = ss_wdat;
        end
        if (ss_hi_we) begin
            cnt_d = IRQ_W'({ss_wdat, cnt_q[7:0]});
        end
    end

    always_ff @(negedge m2) begin
        if (!map_rst_n) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            irq_q <= irq_d;
        end
    end

    assign counter = cnt_q;
    assign irq_en  = en_q;
    assign irq     = irq_q;
endmodule

// File: rtl/map_bankwin_irq.sv
// map_bankwin_irq: NES mapper with an 8 KB PRG window at $6000-$7FFF and fixed last 32 KB at
// $8000-$FFFF. It also has a CHR bank register, mirroring control, a CPU-cycle IRQ and
// save-state access.
//   m2         CPU M2; all state changes on its falling edge
//   map_rst_n  synchronous active-low reset
//   bus        map_bankwin_irq_if slave: CPU bus, save-state port, PRG/CHR/mirroring/IRQ outputs
module map_bankwin_irq
    import map_bankwin_irq_pkg::*;
#(
    parameter int unsigned PRG_BANK_W = 4,
    parameter int unsigned CHR_BANK_W = 2,
    parameter int unsigned IRQ_W      = 15,
    parameter int unsigned IRQ_PERIOD = 24576,
    parameter bit          MIR_RST    = 1'b1
) (
    input  logic                m2,
    input  logic                map_rst_n,
    map_bankwin_irq_if.slave    bus
);
    localparam int unsigned      PA_W     = PRG_BANK_W + 13;
    localparam logic [PA_W-1:0]  FIX_ONES = '1;

    logic [PRG_BANK_W-1:0] prg_q, prg_d;
    logic [CHR_BANK_W-1:0] chr_q, chr_d;
    logic                  mir_q, mir_d;
    logic [IRQ_W-1:0]      counter;
    logic                  irq_en;
    logic                  irq;
    logic                  cpu_we;
    logic                  ss_wr;
    logic [2:0]            reg_sel;

    assign cpu_we  = !bus.cpu_ce && !bus.cpu_rw && !bus.ss_act;
    assign ss_wr   = bus.ss_act && bus.ss_we;
    assign reg_sel = bus.cpu_addr[14:12];

    always_comb begin
        prg_d = prg_q;
        chr_d = chr_q;
        mir_d = mir_q;
        if (cpu_we) begin
            case (reg_sel)
                REG_PRG: prg_d = bus.cpu_dat[PRG_BANK_W-1:0];
                REG_CHR: chr_d = bus.cpu_dat[CHR_BANK_W-1:0];
                REG_CTL: mir_d = bus.cpu_dat[CTL_MIR];
                default: ;
            endcase
        end
        if (ss_wr) begin
            case (bus.ss_addr)
                SS_PRG:  prg_d = bus.cpu_dat[PRG_BANK_W-1:0];
                SS_CHR:  chr_d = bus.cpu_dat[CHR_BANK_W-1:0];
                SS_CTL:  mir_d = bus.cpu_dat[CTL_MIR];
                default: ;
            endcase
        end
    end

    always_ff @(negedge m2) begin
        if (!map_rst_n) begin
            prg_q <= '0;
            chr_q <= '0;
            mir_q <= MIR_RST;
        end else begin
            prg_q <= prg_d;
            chr_q <= chr_d;
            mir_q <= mir_d;
        end
    end

    map_irq_cyc #(
        .IRQ_W      (IRQ_W),
        .IRQ_PERIOD (IRQ_PERIOD)
    ) u_irq (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .freeze    (bus.ss_act),
        .en_we     (cpu_we && (reg_sel == REG_CTL)),
        .en_wdat   (bus.cpu_dat[CTL_IRQ_EN]),
        .ack       (cpu_we && (reg_sel == REG_ACK)),
        .ss_ctl_we (ss_wr && (bus.ss_addr == SS_CTL)),
        .ss_lo_we  (ss_wr && (bus.ss_addr == SS_CNTL)),
        .ss_hi_we  (ss_wr && (bus.ss_addr == SS_CNTH)),
        .ss_wdat   (bus.cpu_dat),
        .counter   (counter),
        .irq_en    (irq_en),
        .irq       (irq)
    );

    // The fixed region is all-ones above A14..A0. The shift and cast truncate it when the
    // PRG address is narrower than 15 bits.
    assign bus.prg_addr = bus.cpu_ce ? {prg_q, bus.cpu_addr[12:0]}
                                     : ((FIX_ONES << 15) | PA_W'(bus.cpu_addr));
    assign bus.rom_ce   = ((bus.cpu_addr[14:13] == 2'b11) && bus.cpu_ce) || !bus.cpu_ce;
    assign bus.chr_bank = chr_q;
    assign bus.mir_v    = mir_q;
    assign bus.irq      = irq;

    always_comb begin
        bus.ss_rdat = 8'hFF;
        case (bus.ss_addr)
            SS_PRG:  bus.ss_rdat = 8'(prg_q);
            SS_CHR:  bus.ss_rdat = 8'(chr_q);
            SS_CTL:  bus.ss_rdat = {5'd0, irq, irq_en, mir_q};
            SS_CNTL: bus.ss_rdat = counter[7:0];
            SS_CNTH: bus.ss_rdat = 8'(counter >> 8);
            SS_RSVD: bus.ss_rdat = 8'h00;
            SS_IDX:  bus.ss_rdat = bus.map_idx;
            default: bus.ss_rdat = 8'hFF;
        endcase
    end
endmodule

// File: tb/tb_map_bankwin_irq.sv
// tb_map_bankwin_irq: directed stimulus for map_bankwin_irq.
// The stimulus process queues the expected observations for the coming cycle. The monitor pops
// and compares them on the next rising m2 edge, midway between the falling edges where the
// mapper state changes.
module tb_map_bankwin_irq;
    localparam int unsigned SEL_PRG = 0;
    localparam int unsigned SEL_CHR = 1;
    localparam int unsigned SEL_MIR = 2;
    localparam int unsigned SEL_IRQ = 3;
    localparam int unsigned SEL_ROM = 4;
    localparam int unsigned SEL_SSR = 5;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    logic m2 = 1'b0;
    logic map_rst_n;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    map_bankwin_irq_if #(.PRG_BANK_W(4), .CHR_BANK_W(2)) bus ();

    map_bankwin_irq #(
        .PRG_BANK_W (4),
        .CHR_BANK_W (2),
        .IRQ_W      (15),
        .IRQ_PERIOD (24576),
        .MIR_RST    (1'b1)
    ) dut (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .bus       (bus)
    );

    always #5 m2 = ~m2;

    function automatic logic [31:0] pick(int unsigned sel);
        case (sel)
            SEL_PRG: return 32'(bus.prg_addr);
            SEL_CHR: return 32'(bus.chr_bank);
            SEL_MIR: return 32'(bus.mir_v);
            SEL_IRQ: return 32'(bus.irq);
            SEL_ROM: return 32'(bus.rom_ce);
            default: return 32'(bus.ss_rdat);
        endcase
    endfunction

    // Monitor.
    always @(posedge m2) begin
        while (sb.size() != 0) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = pick(e.sel);
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got=%0h want=%0h", e.name, act, e.exp);
            end
        end
    end

    task automatic chk(input string name, input int unsigned sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        bus.cpu_addr = a[14:0];
        bus.cpu_ce   = ~a[15];
        bus.cpu_rw   = 1'b1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr = a[14:0];
        bus.cpu_ce   = ~a[15];
        bus.cpu_rw   = 1'b0;
        bus.cpu_dat  = d;
    endtask

    task automatic ss_wr(input logic [7:0] idx, input logic [7:0] d);
        cpu_rd(16'h6000);
        bus.ss_we   = 1'b1;
        bus.ss_addr = idx;
        bus.cpu_dat = d;
    endtask

    task automatic run(input int n);
        cpu_rd(16'h6000);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        map_rst_n    = 1'b0;
        bus.ss_act   = 1'b0;
        bus.ss_we    = 1'b0;
        bus.ss_addr  = 8'd3;
        bus.map_idx  = 8'hA5;
        bus.cpu_dat  = 8'h00;
        cpu_rd(16'h6000);
        tick();
        tick();

        total++;
        if (bus.irq !== 1'b0 || bus.mir_v !== 1'b1 || bus.chr_bank !== 2'd0
            || bus.prg_addr !== 17'h00000) begin
            bad++;
            $display("FAIL rst_state: irq=%0b mir=%0b chr=%0h prg=%0h",
                     bus.irq, bus.mir_v, bus.chr_bank, bus.prg_addr);
        end

        // Reset state and the fixed/window mapping.
        map_rst_n = 1'b1;
        cpu_rd(16'h6000);
        chk("rst_prg_6000", SEL_PRG, 32'h00000);
        chk("rst_rom_6000", SEL_ROM, 32'd1);
        chk("rst_mir", SEL_MIR, 32'd1);
        chk("rst_irq", SEL_IRQ, 32'd0);
        chk("rst_chr", SEL_CHR, 32'd0);
        tick();
        cpu_rd(16'h8000);
        chk("prg_8000", SEL_PRG, 32'h18000);
        chk("rom_8000", SEL_ROM, 32'd1);
        tick();
        cpu_rd(16'h4020);
        chk("rom_4020", SEL_ROM, 32'd0);
        tick();
        cpu_rd(16'hFFFF);
        chk("prg_ffff", SEL_PRG, 32'h1FFFF);
        tick();

        // Bank registers.
        cpu_wr(16'h8000, 8'h0B);
        tick();
        cpu_rd(16'h7123);
        chk("prg_7123_b11", SEL_PRG, 32'h17123);
        tick();
        cpu_wr(16'h8FFF, 8'hF3);
        tick();
        cpu_rd(16'h6000);
        bus.ss_addr = 8'd0;
        chk("prg_6000_b3", SEL_PRG, 32'h06000);
        chk("ss_prg_3", SEL_SSR, 32'h03);
        tick();
        cpu_wr(16'h9000, 8'h06);
        tick();
        cpu_rd(16'h6000);
        chk("chr_2", SEL_CHR, 32'd2);
        tick();
        cpu_wr(16'hC000, 8'hFF);
        tick();
        cpu_rd(16'h6000);
        bus.ss_addr = 8'd2;
        chk("c000_prg", SEL_PRG, 32'h06000);
        chk("c000_chr", SEL_CHR, 32'd2);
        chk("c000_ctl", SEL_SSR, 32'h01);
        tick();

        // IRQ timing.
        bus.ss_addr = 8'd3;
        cpu_wr(16'hA000, 8'h02);
        tick();
        run(24574);
        chk("irq_pre", SEL_IRQ, 32'd0);
        chk("cnt_pre", SEL_SSR, 32'hFF);
        chk("mir_h", SEL_MIR, 32'd0);
        tick();
        chk("irq_hit", SEL_IRQ, 32'd1);
        chk("cnt_wrap", SEL_SSR, 32'h00);
        tick();

        // Acknowledge clears irq while the counter keeps running.
        cpu_wr(16'hB000, 8'h00);
        chk("ack_irq", SEL_IRQ, 32'd0);
        chk("ack_cnt", SEL_SSR, 32'h01);
        tick();
        run(24573);
        chk("irq2_pre", SEL_IRQ, 32'd0);
        tick();
        chk("irq2_hit", SEL_IRQ, 32'd1);
        chk("cnt2_wrap", SEL_SSR, 32'h00);
        tick();

        // Disable clears the counter and irq.
        cpu_wr(16'hA000, 8'h02);
        tick();
        run(100);
        cpu_wr(16'hA000, 8'h01);
        chk("dis_irq", SEL_IRQ, 32'd0);
        chk("dis_mir", SEL_MIR, 32'd1);
        chk("dis_cnt", SEL_SSR, 32'h00);
        tick();
        run(29999);

        total++;
        if (bus.irq !== 1'b0) begin
            bad++;
            $display("FAIL dis_wait_expired: irq=%0b", bus.irq);
        end

        bus.ss_addr = 8'd4;
        chk("dis_quiet_irq", SEL_IRQ, 32'd0);
        chk("dis_cnth", SEL_SSR, 32'h00);
        tick();

        // Save-state.
        bus.ss_act = 1'b1;
        ss_wr(8'd3, 8'hFE);
        tick();
        ss_wr(8'd4, 8'h5F);
        tick();
        ss_wr(8'd2, 8'h02);
        tick();
        ss_wr(8'd1, 8'hFD);
        tick();
        bus.ss_we   = 1'b0;
        bus.ss_addr = 8'd0;
        cpu_wr(16'h8000, 8'h05);
        chk("ss_cpu_ignored", SEL_SSR, 32'h03);
        chk("ss_chr_trunc", SEL_CHR, 32'd1);
        chk("ss_mir", SEL_MIR, 32'd0);
        tick();
        cpu_rd(16'h6000);
        bus.ss_addr = 8'd3;
        chk("ss_frozen_lo", SEL_SSR, 32'hFE);
        tick();
        bus.ss_addr = 8'd4;
        chk("ss_frozen_hi", SEL_SSR, 32'h5F);
        tick();
        bus.ss_act  = 1'b0;
        bus.ss_addr = 8'd127;
        chk("ss_rel_irq0", SEL_IRQ, 32'd0);
        chk("ss_idx127", SEL_SSR, 32'hA5);
        tick();
        bus.ss_addr = 8'd9;
        chk("ss_rel_irq1", SEL_IRQ, 32'd1);
        chk("ss_idx9", SEL_SSR, 32'hFF);
        tick();
        bus.ss_addr = 8'd2;
        chk("ss_ctl_rd", SEL_SSR, 32'h06);
        tick();
        bus.ss_addr = 8'd5;
        chk("ss_rsvd", SEL_SSR, 32'h00);
        tick();

        // Reset overrides a concurrent write while counting.
        map_rst_n   = 1'b0;
        bus.ss_addr = 8'd0;
        cpu_wr(16'h8000, 8'h07);
        chk("rstw_irq", SEL_IRQ, 32'd0);
        chk("rstw_prg", SEL_SSR, 32'h00);
        chk("rstw_mir", SEL_MIR, 32'd1);
        chk("rstw_chr", SEL_CHR, 32'd0);
        tick();
        map_rst_n   = 1'b1;
        bus.ss_addr = 8'd3;
        cpu_rd(16'h6000);
        chk("rstw_prg_addr", SEL_PRG, 32'h00000);
        chk("rstw_cnt", SEL_SSR, 32'h00);
        tick();
        run(5);
        bus.ss_addr = 8'd2;
        chk("rstw_ctl", SEL_SSR, 32'h01);
        chk("rstw_irq_hold", SEL_IRQ, 32'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
